// File: rtl/instr_decode_stage_pkg.sv
// Shared definitions for the RV32I/RV64I front-decode stage: format codes,
// opcode[6:2] values and funct7 values.
package instr_decode_stage_pkg;

    typedef enum logic [2:0] {
        FMT_I   = 3'b000,
        FMT_U   = 3'b001,
        FMT_UJ  = 3'b010,
        FMT_S   = 3'b011,
        FMT_SB  = 3'b100,
        FMT_R   = 3'b101,
        FMT_UNK = 3'b111
    } fmt_e;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_IMM32  = 5'b00110;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_OP32   = 5'b01110;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Only R, S and SB encodings carry a meaningful rs2 field.
    function automatic logic fmt_has_rs2(input fmt_e fmt);
        return (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_SB);
    endfunction

endpackage

// File: rtl/instr_fmt_classify.sv
// Combinational classifier: instruction format, sign-extended immediate,
// register indices and illegal-encoding flag for one 32-bit instruction word.
module instr_fmt_classify
    import instr_decode_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit EN_RVM = 1'b0
) (
    input  logic [31:0]     i_instr,
    output fmt_e            o_fmt,
    output logic [XLEN-1:0] o_imm,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [4:0]      o_rd,
    output logic            o_illegal
);

    logic [4:0]  w_op;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm32;
    logic        w_funct7_ok;

    assign w_op     = i_instr[6:2];
    assign w_funct7 = i_instr[31:25];

    always_comb begin
        o_fmt = FMT_UNK;
        case (w_op)
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM: o_fmt = FMT_I;
            OP_AUIPC, OP_LUI:                              o_fmt = FMT_U;
            OP_JAL:                                        o_fmt = FMT_UJ;
            OP_STORE:                                      o_fmt = FMT_S;
            OP_BRANCH:                                     o_fmt = FMT_SB;
            OP_OP, OP_OP32:                                o_fmt = FMT_R;
            default:                                       o_fmt = FMT_UNK;
        endcase
    end

    // NOTE: every combinational output gets a default before the case, so no path can infer a latch.
    always_comb begin
        w_imm32 = '0;
        case (o_fmt)
            FMT_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            FMT_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_SB:  w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_U:   w_imm32 = {i_instr[31:12], 12'b0};
            FMT_UJ:  w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    // Widen to XLEN by replicating bit 31; a no-op when XLEN is 32.
    always_comb begin
        o_imm        = {XLEN{w_imm32[31]}};
        o_imm[31:0]  = w_imm32;
    end

    assign o_rd  = (o_fmt == FMT_S || o_fmt == FMT_SB) ? 5'd0 : i_instr[11:7];
    assign o_rs1 = (o_fmt == FMT_U || o_fmt == FMT_UJ) ? 5'd0 : i_instr[19:15];
    assign o_rs2 = fmt_has_rs2(o_fmt) ? i_instr[24:20] : 5'd0;

    assign w_funct7_ok = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT) ||
                         (EN_RVM && (w_funct7 == F7_MULDIV));

    assign o_illegal = (o_fmt == FMT_UNK) ||
                       (i_instr[1:0] != 2'b11) ||
                       ((o_fmt == FMT_R) && !w_funct7_ok) ||
                       ((w_op == OP_OP32) && (XLEN == 32));

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage: classifies at the input, then holds entries in a
// main register plus one skid register so fetch can stream at 1 instr/cycle.
module instr_decode_stage
    import instr_decode_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit EN_RVM = 1'b0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [2:0]       out_fmt,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        fmt_e            fmt;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            illegal;
    } entry_t;

    entry_t          w_in_entry;
    entry_t          r_main;
    entry_t          r_skid;
    logic            r_main_valid;
    logic            r_skid_valid;
    logic [CNT_W-1:0] r_illegal_cnt;
    logic            w_accept;
    logic            w_retire;

    fmt_e            w_fmt;
    logic [XLEN-1:0] w_imm;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic            w_illegal;

    instr_fmt_classify #(
        .XLEN   (XLEN),
        .EN_RVM (EN_RVM)
    ) u_classify (
        .i_instr   (in_instr),
        .o_fmt     (w_fmt),
        .o_imm     (w_imm),
        .o_rs1     (w_rs1),
        .o_rs2     (w_rs2),
        .o_rd      (w_rd),
        .o_illegal (w_illegal)
    );

    assign w_in_entry = '{pc: in_pc, fmt: w_fmt, imm: w_imm, rs1: w_rs1,
                          rs2: w_rs2, rd: w_rd, illegal: w_illegal};

    // The skid register is the only thing that can block fetch.
    assign in_ready = !r_skid_valid;
    assign w_accept = in_valid && in_ready;
    assign w_retire = r_main_valid && out_ready;

    // NOTE: payload registers are reset along with the valid bits so every output reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid) begin
            if (w_retire) begin
                r_main       <= r_skid;
                r_skid_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_main_valid || w_retire) begin
                r_main       <= w_in_entry;
                r_main_valid <= 1'b1;
            end else begin
                r_skid       <= w_in_entry;
                r_skid_valid <= 1'b1;
            end
        end else if (w_retire) begin
            r_main_valid <= 1'b0;
        end
    end

    // A retire coinciding with flush still counts: flush only kills held entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_cnt <= '0;
        end else if (w_retire && r_main.illegal && (r_illegal_cnt != {CNT_W{1'b1}})) begin
            r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
        end
    end

    assign out_valid   = r_main_valid;
    assign out_pc      = r_main.pc;
    assign out_fmt     = r_main.fmt;
    assign out_imm     = r_main.imm;
    assign out_rs1     = r_main.rs1;
    assign out_rs2     = r_main.rs2;
    assign out_rd      = r_main.rd;
    assign out_illegal = r_main.illegal;
    assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench: two stage instances (RV32 no-M / 16-bit counter, RV64 with M / 2-bit
// counter) share stimulus; a monitor compares both against a behavioural decode model.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = '0;

    logic        a_in_ready, a_out_valid, a_ill;
    logic [31:0] a_out_pc, a_out_imm;
    logic [2:0]  a_out_fmt;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [15:0] a_cnt;

    logic        b_in_ready, b_out_valid, b_ill;
    logic [63:0] b_out_pc, b_out_imm;
    logic [2:0]  b_out_fmt;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [1:0]  b_cnt;

    instr_decode_stage #(.XLEN(32), .EN_RVM(1'b0), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc), .out_fmt(a_out_fmt),
        .out_imm(a_out_imm), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd),
        .out_illegal(a_ill), .illegal_cnt(a_cnt)
    );

    instr_decode_stage #(.XLEN(64), .EN_RVM(1'b1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc), .out_fmt(b_out_fmt),
        .out_imm(b_out_imm), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd),
        .out_illegal(b_ill), .illegal_cnt(b_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic        ill_a, ill_b;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          occ = 0;
    int unsigned cnt_a = 0;
    int unsigned cnt_b = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_retired = 0;

    localparam logic [4:0] OPS [12] = '{5'b00000, 5'b00100, 5'b00110, 5'b11001, 5'b11100, 5'b00101,
                                        5'b01101, 5'b11011, 5'b01000, 5'b11000, 5'b01100, 5'b01110};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decode rules restated arithmetically: immediates built from signed shifts and
    // weighted field values rather than bit concatenation.
    function automatic exp_t model(input logic [31:0] w, input logic [63:0] pc);
        exp_t   e;
        longint sw, f_a, f_b, f_c;
        int     op;
        logic   rok_a, rok_b, base;
        op    = int'(w[6:2]);
        sw    = {{32{w[31]}}, w};
        e.pc  = pc;
        case (op)
            0, 4, 6, 25, 28: e.fmt = 3'd0;
            5, 13:           e.fmt = 3'd1;
            27:              e.fmt = 3'd2;
            8:               e.fmt = 3'd3;
            24:              e.fmt = 3'd4;
            12, 14:          e.fmt = 3'd5;
            default:         e.fmt = 3'd7;
        endcase
        case (e.fmt)
            3'd0: e.imm = sw >>> 20;
            3'd1: e.imm = (sw >>> 12) * 4096;
            3'd2: begin
                f_a = longint'(w[19:12]); f_b = longint'(w[20]); f_c = longint'(w[30:21]);
                e.imm = (sw >>> 31) * 1048576 + f_a * 4096 + f_b * 2048 + f_c * 2;
            end
            3'd3: begin
                f_a = longint'(w[11:7]);
                e.imm = (sw >>> 25) * 32 + f_a;
            end
            3'd4: begin
                f_a = longint'(w[7]); f_b = longint'(w[30:25]); f_c = longint'(w[11:8]);
                e.imm = (sw >>> 31) * 4096 + f_a * 2048 + f_b * 32 + f_c * 2;
            end
            default: e.imm = '0;
        endcase
        e.rd  = (e.fmt == 3'd3 || e.fmt == 3'd4) ? 5'd0 : w[11:7];
        e.rs1 = (e.fmt == 3'd1 || e.fmt == 3'd2) ? 5'd0 : w[19:15];
        e.rs2 = (e.fmt == 3'd5 || e.fmt == 3'd3 || e.fmt == 3'd4) ? w[24:20] : 5'd0;
        base    = (e.fmt == 3'd7) || (w[1:0] != 2'b11);
        rok_a   = (w[31:25] == 7'd0) || (w[31:25] == 7'd32);
        rok_b   = rok_a || (w[31:25] == 7'd1);
        e.ill_a = base || (e.fmt == 3'd5 && !rok_a) || (op == 14);
        e.ill_b = base || (e.fmt == 3'd5 && !rok_b);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          r;
        w = $urandom;
        r = $urandom_range(0, 19);
        if (r < 17)       w[6:0] = {OPS[$urandom_range(0, 11)], 2'b11};
        else if (r < 19)  w[1:0] = 2'b11;
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'd0;
            1: w[31:25] = 7'd32;
            2: w[31:25] = 7'd1;
            default: ;
        endcase
        return w;
    endfunction

    // Monitor: occupancy model for handshake, in-order comparison, count model.
    always @(negedge clk) begin
        if (rst_n) begin
            occ = q.size();
            check("a_out_valid", a_out_valid, occ != 0);
            check("b_out_valid", b_out_valid, occ != 0);
            check("a_in_ready", a_in_ready, occ < 2);
            check("b_in_ready", b_in_ready, occ < 2);
            check("a_illegal_cnt", a_cnt, cnt_a);
            check("b_illegal_cnt", b_cnt, cnt_b);
            if (occ != 0) begin
                mon_e = q[0];
                check("a_pc", a_out_pc, mon_e.pc[31:0]);
                check("a_fmt", a_out_fmt, mon_e.fmt);
                check("a_imm", a_out_imm, mon_e.imm[31:0]);
                check("a_rs1", a_rs1, mon_e.rs1);
                check("a_rs2", a_rs2, mon_e.rs2);
                check("a_rd", a_rd, mon_e.rd);
                check("a_illegal", a_ill, mon_e.ill_a);
                check("b_pc", b_out_pc, mon_e.pc);
                check("b_fmt", b_out_fmt, mon_e.fmt);
                check("b_imm", b_out_imm, mon_e.imm);
                check("b_rs1", b_rs1, mon_e.rs1);
                check("b_rs2", b_rs2, mon_e.rs2);
                check("b_rd", b_rd, mon_e.rd);
                check("b_illegal", b_ill, mon_e.ill_b);
                if (out_ready) begin
                    if (mon_e.ill_a && cnt_a < 65535) cnt_a++;
                    if (mon_e.ill_b && cnt_b < 3) cnt_b++;
                    void'(q.pop_front());
                    n_retired++;
                end
            end
            if (flush) q.delete();
            if (in_valid && occ < 2 && !flush) q.push_back(model(in_instr, in_pc));
        end
    end

    task automatic send(input logic [31:0] ins, input logic [63:0] pc);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = a_in_ready;
        end
        check("send_accepted", ok, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        q.delete();
        cnt_a = 0;
        cnt_b = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic reset_outputs_check(input string tag);
        check({tag, "_a_out_valid"}, a_out_valid, 0);
        check({tag, "_a_in_ready"}, a_in_ready, 1);
        check({tag, "_a_out_pc"}, a_out_pc, 0);
        check({tag, "_a_out_fmt"}, a_out_fmt, 0);
        check({tag, "_a_out_imm"}, a_out_imm, 0);
        check({tag, "_a_regs"}, {a_rs1, a_rs2, a_rd}, 0);
        check({tag, "_a_illegal"}, a_ill, 0);
        check({tag, "_a_cnt"}, a_cnt, 0);
        check({tag, "_b_out_valid"}, b_out_valid, 0);
        check({tag, "_b_in_ready"}, b_in_ready, 1);
        check({tag, "_b_out_imm"}, b_out_imm, 0);
        check({tag, "_b_cnt"}, b_cnt, 0);
    endtask

    // One instruction with out_ready=1: checks 1-cycle latency and the decoded fields.
    task automatic directed(input string tag, input logic [31:0] ins, input logic [63:0] pc,
                            input logic [2:0] fmt, input logic [63:0] imm, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic ill_a, input logic ill_b);
        @(posedge clk);
        #1 in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        @(negedge clk);
        check({tag, "_pre_valid"}, a_out_valid, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_valid"}, a_out_valid, 1);
        check({tag, "_pc"}, a_out_pc, pc[31:0]);
        check({tag, "_fmt"}, a_out_fmt, fmt);
        check({tag, "_imm32"}, a_out_imm, imm[31:0]);
        check({tag, "_imm64"}, b_out_imm, imm);
        check({tag, "_rd"}, a_rd, rd);
        check({tag, "_rs1"}, a_rs1, rs1);
        check({tag, "_illegal_a"}, a_ill, ill_a);
        check({tag, "_illegal_b"}, b_ill, ill_b);
        check({tag, "_fmt_b"}, b_out_fmt, fmt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, n_errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start_retired;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_outputs_check("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;

        out_ready = 1'b1;
        directed("addi", 32'hFFF00093, 64'h100, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 5'd0, 1'b0, 1'b0);
        directed("lui",  32'h123452B7, 64'h104, 3'd1, 64'h0000_0000_1234_5000, 5'd5, 5'd0, 1'b0, 1'b0);
        directed("sw",   32'h0020A423, 64'h108, 3'd3, 64'h8, 5'd0, 5'd1, 1'b0, 1'b0);
        directed("beq",  32'hFE000EE3, 64'h10C, 3'd4, 64'hFFFF_FFFF_FFFF_FFFC, 5'd0, 5'd0, 1'b0, 1'b0);
        directed("mul",  32'h02208033, 64'h110, 3'd5, 64'h0, 5'd0, 5'd1, 1'b1, 1'b0);
        check("mul_cnt_before", a_cnt, 0);
        @(posedge clk);
        #1 check("mul_cnt_after", a_cnt, 1);
        directed("zero", 32'h00000000, 64'h114, 3'd0, 64'h0, 5'd0, 5'd0, 1'b1, 1'b1);
        @(posedge clk);
        #1 check("directed_cnt_a", a_cnt, 2);
        check("directed_cnt_b", b_cnt, 1);

        // Backpressure: three back-to-back entries, downstream stalled.
        out_ready = 1'b0;
        start_retired = n_retired;
        send(32'h00100093, 64'h200);
        send(32'h00200113, 64'h204);
        check("bp_in_ready_a", a_in_ready, 0);
        check("bp_in_ready_b", b_in_ready, 0);
        in_valid = 1'b1;
        in_instr = 32'h00300193;
        in_pc    = 64'h208;
        repeat (3) @(posedge clk);
        #1 check("bp_hold_pc", a_out_pc, 32'h200);
        check("bp_hold_ready", a_in_ready, 0);
        out_ready = 1'b1;
        send(32'h00300193, 64'h208);
        for (int n = 0; n < 20 && n_retired < start_retired + 3; n++) @(posedge clk);
        #1 check("bp_retired", n_retired - start_retired, 3);

        // Flush with main and skid both full.
        out_ready = 1'b0;
        send(32'h00400213, 64'h300);
        send(32'h00500293, 64'h304);
        check("flush_full_ready", a_in_ready, 0);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_out_valid_a", a_out_valid, 0);
        check("flush_in_ready_a", a_in_ready, 1);
        check("flush_out_valid_b", b_out_valid, 0);
        check("flush_in_ready_b", b_in_ready, 1);

        // Flush with a retiring illegal entry and a simultaneous offer.
        send(32'h00000000, 64'h400);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        in_pc     = 64'h404;
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        check("flush_retire_valid", a_out_valid, 0);
        check("flush_retire_cnt", a_cnt, 3);
        @(posedge clk);
        #1 check("flush_discard_valid", a_out_valid, 0);

        // Randomised traffic with an asynchronous reset pulse part-way through.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1 in_valid = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc     = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            if (i == 450) begin
                #1 rst_n = 1'b0;
                #1 reset_outputs_check("midreset");
                q.delete();
                cnt_a    = 0;
                cnt_b    = 0;
                flush    = 1'b0;
                in_valid = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);

        // Counter saturation on the 2-bit instance.
        do_reset();
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(32'h00000000, 64'h500 + 64'(4 * i));
        repeat (2) @(posedge clk);
        #1 check("sat_cnt_b", b_cnt, 3);
        check("sat_cnt_a", a_cnt, 5);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
